// File: rtl/cpu6_ifu_fetch_pkg.sv
// Shared fetch-unit constants: word width, icache address width, reset PC.
// Imported by the fetch stage and its queue.
package cpu6_ifu_fetch_pkg;
    localparam int CPU6_XLEN = 32;
    localparam int CPU6_IAW  = 8;
    localparam logic [CPU6_IAW-1:0] CPU6_RESET_PC = 8'h00;
endpackage

// File: rtl/cpu6_fetch_fifo.sv
// Synchronous register-based FIFO holding {pc, inst} entries for the fetch stage.
// Flush empties it in one cycle; head data comes straight from the entry registers.
module cpu6_fetch_fifo
    import cpu6_ifu_fetch_pkg::*;
#(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & (count_q != CW'(DEPTH));
    assign do_pop  = pop & (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entries are cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/cpu6_ifu_fetch.sv
// Instruction fetch stage: owns the PC, addresses the icache and queues
// {pc, inst} for decode; a redirect flushes the queue and restarts fetch.
module cpu6_ifu_fetch
    import cpu6_ifu_fetch_pkg::*;
#(
    parameter int             XLEN     = CPU6_XLEN,
    parameter int             AW       = CPU6_IAW,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = CPU6_RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_en,
    output logic [AW-1:0]               icache_a,
    input  logic [XLEN-1:0]             icache_q,
    input  logic                        redirect_valid,
    input  logic [AW-1:0]               redirect_pc,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [XLEN-1:0]             inst,
    output logic [AW-1:0]               inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]  fq_count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]      pc_q, pc_d;
    logic               push;
    logic               pop;
    logic               full;
    logic [AW+XLEN-1:0] head;

    // Full blocks push regardless of pop so ready never reaches the address path.
    assign full       = (fq_count == CW'(DEPTH));
    assign inst_valid = (fq_count != '0);
    assign push       = fetch_en & ~redirect_valid & ~full;
    assign pop        = inst_valid & inst_ready;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_valid: pc_d = redirect_pc;
            push:           pc_d = pc_q + AW'(1);
            default:        pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    cpu6_fetch_fifo #(
        .W     (AW + XLEN),
        .DEPTH (DEPTH)
    ) u_fq (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pc_q, icache_q}),
        .rdata (head),
        .count (fq_count)
    );

    assign icache_a = pc_q;
    assign inst_pc  = head[AW+XLEN-1:XLEN];
    assign inst     = head[XLEN-1:0];
endmodule

// File: tb/tb_cpu6_ifu_fetch.sv
// Fetch-stage bench: directed scenarios then random traffic, checked
// against a queue-based model of the fetch rules.
module tb_cpu6_ifu_fetch;
    import cpu6_ifu_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [7:0]  icache_a;
    logic [31:0] icache_q;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic [2:0]  fq_count;

    always #5 clk = ~clk;

    assign icache_q = 32'hA500_0000 | {24'h0, icache_a};

    cpu6_ifu_fetch #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .icache_a       (icache_a),
        .icache_q       (icache_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fq_count       (fq_count)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] d;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] mpc;
    bit         armed;
    bit         zero_head;
    int         checks;
    int         fails;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit rv,
                        input logic [7:0] rpc, input bit rdy);
        ent_t e;
        bit   full;
        @(negedge clk);
        if (armed) begin
            chk("fq_count", 64'(fq_count), 64'(mq.size()));
            chk("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
            chk("icache_a", 64'(icache_a), 64'(mpc));
            if (mq.size() != 0) begin
                chk("inst", 64'(inst), 64'(mq[0].d));
                chk("inst_pc", 64'(inst_pc), 64'(mq[0].pc));
            end else if (zero_head) begin
                chk("rst_inst", 64'(inst), 64'h0);
                chk("rst_inst_pc", 64'(inst_pc), 64'h0);
            end
        end
        reset          = r;
        fetch_en       = en;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        zero_head      = 1'b0;
        if (r) begin
            mq.delete();
            mpc       = CPU6_RESET_PC;
            zero_head = 1'b1;
            armed     = 1'b1;
        end else if (rv) begin
            mq.delete();
            mpc = rpc;
        end else begin
            full = (mq.size() == DEPTH);
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (en && !full) begin
                e.pc = mpc;
                e.d  = 32'hA500_0000 | {24'h0, mpc};
                mq.push_back(e);
                mpc = mpc + 8'd1;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        inst_ready     = 1'b0;
        armed          = 1'b0;
        zero_head      = 1'b0;
        checks         = 0;
        fails          = 0;
        mpc            = 8'h00;

        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 1);
        // Stall decode until the queue fills, then drain in order.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 1);
        // Three entries queued, then redirect to 0x40.
        step(0, 1, 1, 8'h30, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
        step(0, 1, 1, 8'h40, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 1);
        // Address wrap.
        step(0, 1, 1, 8'hFE, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 1);
        // Redirect in the same cycle the head (pc 05) is popped.
        step(0, 1, 1, 8'h05, 1);
        step(0, 1, 0, 8'h00, 1);
        step(0, 1, 1, 8'h20, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 1);
        // Back-to-back redirects.
        step(0, 1, 1, 8'h10, 1);
        step(0, 1, 1, 8'h80, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
        // Fetch disabled while draining.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h60, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
        // Reset mid-stream.
        step(1, 1, 1, 8'h33, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] rpc;
            rpc = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                              : 8'hFC | 8'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 rpc,
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
